// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity selectors and default sizing.
// The RX datapath imports the same package so both directions stay consistent.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE       = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/tx_baud_counter.sv
// Edge/bit counter pair for the transmitter: the edge counter times one
// serial bit (0..prescale-1), the bit counter tallies completed data bits.
module tx_baud_counter #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic                  bit_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  edge_tc,
    output logic [BIT_W-1:0]      bit_cnt
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;

    assign edge_tc = cnt_en && (edge_q == (prescale - PRESCALE_W'(1)));
    assign bit_cnt = bit_q;

    // Next-count logic: clear restarts a frame, terminal count wraps the edge counter
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (cnt_clr) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (cnt_en) begin
            if (edge_tc) begin
                edge_d = '0;
                if (bit_en) begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    // Counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches one word per handshake and sends it LSB-first as
// start / data / optional parity / stop, each bit lasting prescale clk cycles.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(MIN_PRESCALE);

    uart_state_e           state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  bit_en;
    logic                  edge_tc;
    logic [BIT_W-1:0]      bit_cnt;

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign cnt_en = (state_q != ST_IDLE);
    assign bit_en = (state_q == ST_DATA);

    tx_baud_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .bit_en   (bit_en),
        .prescale (prescale_q),
        .edge_tc  (edge_tc),
        .bit_cnt  (bit_cnt)
    );

    // Frame sequencing, config latch, shifter and registered line/busy values
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        prescale_d = prescale_q;
        cnt_clr    = 1'b0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_d    = ST_START;
                    shift_d    = p_data;
                    par_en_d   = par_en;
                    par_bit_d  = (par_typ == PAR_ODD) ? ~(^p_data) : (^p_data);
                    prescale_d = (prescale < MIN_P) ? MIN_P : prescale;
                    cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                if (edge_tc) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (edge_tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (edge_tc) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (edge_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_q;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            prescale_q <= prescale_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: a frame-level model predicts the line and busy
// on every cycle, and directed frames are captured and compared to literals.
module tb_uart_tx_frame;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] p_data = '0;
   logic          data_valid = 1'b0;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [PW-1:0] prescale = 6'd8;
   logic          tx_out;
   logic          busy;

   int nVectors = 0;
   int nMiscompares = 0;

   logic expQ[$];
   logic prevBusy = 1'b0;
   logic expTx = 1'b1;
   logic expBusy = 1'b0;

   logic [15:0] capBits;
   int capLen;
   int capWait;

   uart_tx_frame #(
      .DATA_WIDTH (DW),
      .PRESCALE_W (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
      end
   endtask

   // Drive one request on a negedge and hold data_valid for a single cycle
   task applyStimulus(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [PW-1:0] ps);
      @(negedge clk);
      p_data = d;
      par_en = pe;
      par_typ = pt;
      prescale = ps;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Record mid-bit line values and busy length of the next (or current) frame
   task sampleFrame(input int p);
      int cyc;
      capBits = '0;
      capLen = 0;
      capWait = 0;
      while (!busy && capWait < 200) begin
         @(negedge clk);
         capWait++;
      end
      if (!busy) begin
         checkOutput("frame_start_timeout", {31'd0, busy}, 32'd1);
      end else begin
         cyc = 0;
         while (busy && cyc < 2000) begin
            if ((cyc % p) == (p / 2) && (cyc / p) < 16) capBits[cyc / p] = tx_out;
            capLen++;
            cyc++;
            @(negedge clk);
         end
         if (busy) checkOutput("frame_end_timeout", {31'd0, busy}, 32'd0);
      end
   endtask

   // Frame-level model: on acceptance, expand the whole frame into per-cycle line values
   always begin
      int p;
      @(posedge clk);
      if (!rst) begin
         expQ.delete();
         expTx = 1'b1;
         expBusy = 1'b0;
      end else begin
         if (!prevBusy && expQ.size() == 0 && data_valid) begin
            p = (int'(prescale) < 4) ? 4 : int'(prescale);
            for (int r = 0; r < p; r++) expQ.push_back(1'b0);
            for (int k = 0; k < DW; k++)
               for (int r = 0; r < p; r++) expQ.push_back(p_data[k]);
            if (par_en)
               for (int r = 0; r < p; r++) expQ.push_back(par_typ ? ~(^p_data) : (^p_data));
            for (int r = 0; r < p; r++) expQ.push_back(1'b1);
         end
         if (expQ.size() > 0) begin
            expTx = expQ.pop_front();
            expBusy = 1'b1;
         end else begin
            expTx = 1'b1;
            expBusy = 1'b0;
         end
      end
      prevBusy = expBusy;
      #1;
      checkOutput("cycle_tx_out", {31'd0, tx_out}, {31'd0, expTx});
      checkOutput("cycle_busy", {31'd0, busy}, {31'd0, expBusy});
   end

   // Watchdog so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed frames with hand-computed line patterns and busy lengths
   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_tx_out", {31'd0, tx_out}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 8N1, 0xA5, prescale 8
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8);
      sampleFrame(8);
      checkOutput("a5_bits", {22'd0, capBits[9:0]}, 32'h34A);
      checkOutput("a5_busy_len", capLen, 80);

      // even parity, 0x03, prescale 16
      applyStimulus(8'h03, 1'b1, 1'b0, 6'd16);
      sampleFrame(16);
      checkOutput("even_03_bits", {21'd0, capBits[10:0]}, 32'h406);
      checkOutput("even_03_busy_len", capLen, 176);

      // odd parity, 0x03
      applyStimulus(8'h03, 1'b1, 1'b1, 6'd16);
      sampleFrame(16);
      checkOutput("odd_03_bits", {21'd0, capBits[10:0]}, 32'h606);
      checkOutput("odd_03_busy_len", capLen, 176);

      // odd parity, 0x07
      applyStimulus(8'h07, 1'b1, 1'b1, 6'd16);
      sampleFrame(16);
      checkOutput("odd_07_bits", {21'd0, capBits[10:0]}, 32'h40E);

      // request during a frame is dropped
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8);
      fork
         sampleFrame(8);
         begin
            repeat (20) @(negedge clk);
            p_data = 8'h3C;
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
         end
      join
      checkOutput("ignored_bits", {22'd0, capBits[9:0]}, 32'h34A);
      checkOutput("ignored_busy_len", capLen, 80);
      repeat (5) @(negedge clk);
      checkOutput("ignored_no_second_frame", {31'd0, busy}, 32'd0);

      // held data_valid: two frames, one idle cycle, prescale change mid-frame
      @(negedge clk);
      p_data = 8'h55;
      par_en = 1'b0;
      prescale = 6'd8;
      data_valid = 1'b1;
      fork
         sampleFrame(8);
         begin
            repeat (20) @(negedge clk);
            prescale = 6'd16;
         end
      join
      checkOutput("held_first_bits", {22'd0, capBits[9:0]}, 32'h2AA);
      checkOutput("held_first_busy_len", capLen, 80);
      checkOutput("held_idle_tx_out", {31'd0, tx_out}, 32'd1);
      checkOutput("held_idle_busy", {31'd0, busy}, 32'd0);
      fork
         sampleFrame(16);
         begin
            @(negedge clk);
            @(negedge clk);
            data_valid = 1'b0;
         end
      join
      checkOutput("held_idle_gap", capWait, 1);
      checkOutput("held_second_bits", {22'd0, capBits[9:0]}, 32'h2AA);
      checkOutput("held_second_busy_len", capLen, 160);

      // asynchronous reset in the middle of the data bits
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8);
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_tx_out", {31'd0, tx_out}, 32'd1);
      checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(8'hFF, 1'b0, 1'b0, 6'd8);
      sampleFrame(8);
      checkOutput("post_rst_ff_bits", {22'd0, capBits[9:0]}, 32'h3FE);
      checkOutput("post_rst_ff_busy_len", capLen, 80);

      // prescale below minimum is clamped to 4
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd2);
      sampleFrame(4);
      checkOutput("clamp_bits", {22'd0, capBits[9:0]}, 32'h34A);
      checkOutput("clamp_busy_len", capLen, 40);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
